// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer and its watchdog.
// State encoding is fixed so the control unit's debug view stays stable.
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StMultWait = 3'd1,
        StDivWait  = 3'd2,
        StWrite    = 3'd3,
        StDzero    = 3'd4,
        StTout     = 3'd5
    } state_e;

    // HI/LO source select values
    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

    localparam int unsigned CntWidth = 6;

    function automatic logic is_wait(input state_e s);
        return (s == StMultWait) || (s == StDivWait);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit / arithmetic units and the sequencer.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface muldiv_sequencer_if;

    logic        mult_req;
    logic        div_req;
    logic        abort;
    logic [31:0] operand_b;
    logic        mult_done;
    logic        div_done;

    logic        mult_start;
    logic        div_start;
    logic        hi_write;
    logic        lo_write;
    logic        mux_high;
    logic        mux_low;
    logic        busy;
    logic        op_done;
    logic        div_zero;
    logic        timeout_err;

    modport master (
        output mult_req, div_req, abort, operand_b, mult_done, div_done,
        input  mult_start, div_start, hi_write, lo_write, mux_high, mux_low,
        input  busy, op_done, div_zero, timeout_err
    );

    modport slave (
        input  mult_req, div_req, abort, operand_b, mult_done, div_done,
        output mult_start, div_start, hi_write, lo_write, mux_high, mux_low,
        output busy, op_done, div_zero, timeout_err
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// Wait-cycle counter with clear/enable; flags expiry once TIMEOUT-1 cycles have elapsed.
// The count holds at its maximum so it can never wrap back into a legal window.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic clk,
    input  logic reset_in,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TIMEOUT - 1);
    localparam logic [CntWidth-1:0] MaxCnt  = '1;

    logic [CntWidth-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/muldiv_sequencer.sv
// Shares the multicycle multiplier/divider with the control unit and owns the HI/LO write path.
// Every output is a registered Moore output computed from the next state.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                      clk,
    input  logic                      reset_in,
    muldiv_sequencer_if.slave         bus
);

    state_e state_d, state_q;
    logic   op_d, op_q;
    logic   expired;
    logic   wd_clear;
    logic   wd_enable;

    logic mult_start_d, mult_start_q;
    logic div_start_d, div_start_q;
    logic write_d, write_q;
    logic mux_d, mux_q;
    logic busy_d, busy_q;
    logic op_done_d, op_done_q;
    logic div_zero_d, div_zero_q;
    logic timeout_d, timeout_q;

    // Counts only WAIT cycles that end without the matching done.
    assign wd_clear  = !is_wait(state_q);
    assign wd_enable = ((state_q == StMultWait) && !bus.mult_done) ||
                       ((state_q == StDivWait)  && !bus.div_done);

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset_in  (reset_in),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            StIdle: begin
                if (bus.mult_req) begin
                    state_d = StMultWait;
                    op_d    = SEL_MULT;
                end else if (bus.div_req) begin
                    op_d    = SEL_DIV;
                    state_d = (bus.operand_b != '0) ? StDivWait : StDzero;
                end
            end
            StMultWait: begin
                // abort beats done, done beats the watchdog
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.mult_done) begin
                    state_d = StWrite;
                end else if (expired) begin
                    state_d = StTout;
                end
            end
            StDivWait: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.div_done) begin
                    state_d = StWrite;
                end else if (expired) begin
                    state_d = StTout;
                end
            end
            StWrite, StDzero, StTout: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mult_start_d = (state_q == StIdle) && (state_d == StMultWait);
        div_start_d  = (state_q == StIdle) && (state_d == StDivWait);
        write_d      = (state_d == StWrite);
        mux_d        = write_d ? op_q : mux_q;
        busy_d       = (state_d != StIdle);
        op_done_d    = (state_d == StWrite) || (state_d == StDzero) || (state_d == StTout);
        div_zero_d   = (state_d == StDzero);
        timeout_d    = (state_d == StTout);
    end

    always_ff @(posedge clk) begin
        if (!reset_in) begin
            state_q      <= StIdle;
            op_q         <= SEL_MULT;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            write_q      <= 1'b0;
            mux_q        <= SEL_MULT;
            busy_q       <= 1'b0;
            op_done_q    <= 1'b0;
            div_zero_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            mult_start_q <= mult_start_d;
            div_start_q  <= div_start_d;
            write_q      <= write_d;
            mux_q        <= mux_d;
            busy_q       <= busy_d;
            op_done_q    <= op_done_d;
            div_zero_q   <= div_zero_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.mult_start  = mult_start_q;
    assign bus.div_start   = div_start_q;
    assign bus.hi_write    = write_q;
    assign bus.lo_write    = write_q;
    assign bus.mux_high    = mux_q;
    assign bus.mux_low     = mux_q;
    assign bus.busy        = busy_q;
    assign bus.op_done     = op_done_q;
    assign bus.div_zero    = div_zero_q;
    assign bus.timeout_err = timeout_q;

endmodule
